pipe_ctrl_unit: RTL and testbench

- Parametrised successor to the single-stage control unit of the pipelined processor.
- Decodes an ID-stage opcode/func into ALU control and register-write control.
- Carries that control through EX and a configurable number of writeback stages, producing a clean one-cycle register-file write strobe.
- Detects RAW hazards against in-flight writes; handles external stall and branch flush.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_decode.sv | 52 +++++
 rtl/pipe_ctrl_unit.sv | 104 ++++++++++
 tb/tb_pipe_ctrl_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/ALU encodings and the decoded-control record carried down the pipeline.
package pipe_ctrl_pkg;

  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_RTYPE = 1;
  localparam int unsigned OP_ADDI  = 2;
  localparam int unsigned OP_SUBI  = 3;
  localparam int unsigned OP_STORE = 4;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;

  // Fields sized for the widest supported build; each instance uses the low bits.
  localparam int unsigned CTRL_ALU_W = 8;
  localparam int unsigned CTRL_RD_W  = 8;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [CTRL_ALU_W-1:0] alu;
    logic [CTRL_RD_W-1:0]  rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // True when an in-flight writer targets a non-zero source register.
  function automatic logic raw_hit(input ctrl_t c,
                                   input logic [CTRL_RD_W-1:0] rs1,
                                   input logic [CTRL_RD_W-1:0] rs2);
    logic hit1;
    logic hit2;
    hit1 = (rs1 != '0) && (c.rd == rs1);
    hit2 = (rs2 != '0) && (c.rd == rs2);
    return c.valid & c.wen & (hit1 | hit2);
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode/func decoder producing the pipeline control record and an illegal flag.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned FUNC_W = 2,
  parameter int unsigned REG_AW = 3
) (
  input  logic              valid,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic [REG_AW-1:0] rd,
  output ctrl_t             ctrl,
  output logic              illegal
);

  logic writes;

  always_comb begin
    ctrl                = CTRL_BUBBLE;
    illegal             = 1'b0;
    writes              = 1'b0;
    ctrl.valid          = valid;
    ctrl.rd[REG_AW-1:0] = rd;
    case (opcode)
      OP_W'(OP_NOP): begin
        writes = 1'b0;
      end
      OP_W'(OP_RTYPE): begin
        ctrl.alu[FUNC_W-1:0] = func;
        writes               = 1'b1;
      end
      OP_W'(OP_ADDI): begin
        ctrl.alu = CTRL_ALU_W'(ALU_ADD);
        writes   = 1'b1;
      end
      OP_W'(OP_SUBI): begin
        ctrl.alu = CTRL_ALU_W'(ALU_SUB);
        writes   = 1'b1;
      end
      OP_W'(OP_STORE): begin
        ctrl.alu = CTRL_ALU_W'(ALU_ADD);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    // Register 0 is hardwired zero, so writes to it are dropped here.
    ctrl.wen = valid & writes & (rd != '0);
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode in ID, carry control through EX and WB_DEPTH writeback stages,
// detect RAW hazards against in-flight writers, and honour stall/flush.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OP_W     = 4,
  parameter int unsigned FUNC_W   = 2,
  parameter int unsigned ALU_W    = 3,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned WB_DEPTH = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [FUNC_W-1:0] id_func,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              stall,
  input  logic              flush,
  output logic              id_ready,
  output logic              id_hazard,
  output logic              ex_valid,
  output logic [ALU_W-1:0]  ex_alu_control,
  output logic              ex_wen,
  output logic              wb_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  ctrl_t                dec_ctrl;
  logic                 dec_illegal;
  ctrl_t                ex_q;
  ctrl_t [WB_DEPTH-1:0] wb_q;
  logic                 illegal_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 hazard;
  logic [CTRL_RD_W-1:0] rs1_x;
  logic [CTRL_RD_W-1:0] rs2_x;
  logic                 unused_ctrl_bits;

  pipe_ctrl_decode #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W),
    .REG_AW (REG_AW)
  ) u_decode (
    .valid   (id_valid),
    .opcode  (id_opcode),
    .func    (id_func),
    .rd      (id_rd),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign rs1_x = CTRL_RD_W'(id_rs1);
  assign rs2_x = CTRL_RD_W'(id_rs2);

  // The last WB stage is excluded: the register file writes before it is read.
  always_comb begin
    hazard = raw_hit(ex_q, rs1_x, rs2_x);
    for (int unsigned i = 0; i + 1 < WB_DEPTH; i++) begin
      if (raw_hit(wb_q[i], rs1_x, rs2_x)) begin
        hazard = 1'b1;
      end
    end
  end

  assign id_hazard = id_valid & hazard;
  assign id_ready  = id_valid & ~stall & ~flush & ~hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q      <= CTRL_BUBBLE;
      wb_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ex_q    <= id_ready ? dec_ctrl : CTRL_BUBBLE;
      wb_q[0] <= ex_q;
      for (int unsigned i = 1; i < WB_DEPTH; i++) begin
        wb_q[i] <= wb_q[i-1];
      end
      illegal_q <= id_ready & dec_illegal;
      if (id_ready && dec_illegal && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ex_valid       = ex_q.valid;
  assign ex_alu_control = ex_q.alu[ALU_W-1:0];
  assign ex_wen         = ex_q.wen;
  // wen is only ever set together with valid, so it alone is the write strobe.
  assign wb_write       = wb_q[WB_DEPTH-1].wen;
  assign wb_rd          = wb_q[WB_DEPTH-1].rd[REG_AW-1:0];
  assign illegal        = illegal_q;
  assign illegal_cnt    = cnt_q;

  assign unused_ctrl_bits = ^{ex_q, wb_q};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit (WB_DEPTH=2) plus a CNT_W=2 instance for counter saturation.
module tb_pipe_ctrl_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [1:0] id_func;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic [2:0] id_rd;
  logic       stall;
  logic       flush;

  logic       id_ready;
  logic       id_hazard;
  logic       ex_valid;
  logic [2:0] ex_alu_control;
  logic       ex_wen;
  logic       wb_write;
  logic [2:0] wb_rd;
  logic       illegal;
  logic [7:0] illegal_cnt;

  logic       s_id_ready;
  logic       s_id_hazard;
  logic       s_ex_valid;
  logic [2:0] s_ex_alu_control;
  logic       s_ex_wen;
  logic       s_wb_write;
  logic [2:0] s_wb_rd;
  logic       s_illegal;
  logic [1:0] s_illegal_cnt;

  typedef struct {
    int cyc;
    int a;
    int b;
  } exp_t;

  exp_t exq[$];
  exp_t wbq[$];
  exp_t ilq[$];

  int cyc    = 0;
  int total  = 0;
  int passed = 0;

  pipe_ctrl_unit #(
    .OP_W     (4),
    .FUNC_W   (2),
    .ALU_W    (3),
    .REG_AW   (3),
    .WB_DEPTH (2),
    .CNT_W    (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_func        (id_func),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .stall          (stall),
    .flush          (flush),
    .id_ready       (id_ready),
    .id_hazard      (id_hazard),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_wen         (ex_wen),
    .wb_write       (wb_write),
    .wb_rd          (wb_rd),
    .illegal        (illegal),
    .illegal_cnt    (illegal_cnt)
  );

  pipe_ctrl_unit #(
    .OP_W     (4),
    .FUNC_W   (2),
    .ALU_W    (3),
    .REG_AW   (3),
    .WB_DEPTH (2),
    .CNT_W    (2)
  ) dut_small (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_func        (id_func),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .stall          (stall),
    .flush          (flush),
    .id_ready       (s_id_ready),
    .id_hazard      (s_id_hazard),
    .ex_valid       (s_ex_valid),
    .ex_alu_control (s_ex_alu_control),
    .ex_wen         (s_ex_wen),
    .wb_write       (s_wb_write),
    .wb_rd          (s_wb_rd),
    .illegal        (s_illegal),
    .illegal_cnt    (s_illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every presented output must match the head of its expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (ex_valid) begin
      if (exq.size() == 0) begin
        total++;
        $display("FAIL ex_unexpected: ex_valid=1 alu=%0d wen=%0b, required ex_valid=0 (cycle %0d)",
                 ex_alu_control, ex_wen, cyc);
      end else begin
        e = exq.pop_front();
        chk("ex_cycle", cyc, e.cyc);
        chk("ex_alu", 32'(ex_alu_control), e.a);
        chk("ex_wen", 32'(ex_wen), e.b);
      end
    end
    if (wb_write) begin
      if (wbq.size() == 0) begin
        total++;
        $display("FAIL wb_unexpected: wb_write=1 rd=%0d, required wb_write=0 (cycle %0d)", wb_rd, cyc);
      end else begin
        e = wbq.pop_front();
        chk("wb_cycle", cyc, e.cyc);
        chk("wb_rd", 32'(wb_rd), e.a);
      end
    end
    if (illegal) begin
      if (ilq.size() == 0) begin
        total++;
        $display("FAIL illegal_unexpected: illegal=1 cnt=%0d, required illegal=0 (cycle %0d)",
                 illegal_cnt, cyc);
      end else begin
        e = ilq.pop_front();
        chk("illegal_cycle", cyc, e.cyc);
        chk("illegal_cnt_pulse", 32'(illegal_cnt), e.a);
      end
    end
  end

  // Present one ID instruction for one cycle; expectations are pushed only if it must be accepted.
  task automatic issue(input int op, input int func, input int rs1, input int rs2, input int rd,
                       input bit st, input bit fl, input bit exp_rdy, input bit exp_haz,
                       input int exp_alu, input bit exp_wen, input bit exp_ill, input int exp_cnt);
    @(posedge clk);
    #1;
    id_valid  = 1'b1;
    id_opcode = 4'(op);
    id_func   = 2'(func);
    id_rs1    = 3'(rs1);
    id_rs2    = 3'(rs2);
    id_rd     = 3'(rd);
    stall     = st;
    flush     = fl;
    #1;
    chk("id_ready", 32'(id_ready), 32'(exp_rdy));
    chk("id_hazard", 32'(id_hazard), 32'(exp_haz));
    if (exp_rdy) begin
      exq.push_back('{cyc + 1, exp_alu, int'(exp_wen)});
      if (exp_wen) wbq.push_back('{cyc + 3, rd, 0});
      if (exp_ill) ilq.push_back('{cyc + 1, exp_cnt, 0});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      id_valid = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_opcode = '0; id_func = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_wb_write", 32'(wb_write), 0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 0);
    chk("rst_id_ready", 32'(id_ready), 0);
    reset = 1'b1;

    // op, func, rs1, rs2, rd, stall, flush, ready, hazard, alu, wen, illegal, cnt
    issue(1, 2, 0, 0, 5, 0, 0, 1, 0, 2, 1, 0, 0);
    idle(5);

    issue(2, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0);
    issue(1, 1, 3, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    issue(1, 1, 3, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    issue(1, 1, 3, 0, 4, 0, 0, 1, 0, 1, 1, 0, 0);
    idle(5);

    issue(2, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0);
    issue(1, 1, 0, 0, 4, 0, 0, 1, 0, 1, 1, 0, 0);
    idle(5);

    issue(3, 0, 0, 0, 6, 0, 0, 1, 0, 1, 1, 0, 0);
    issue(4, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    issue(4, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    issue(4, 0, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(5);

    issue(2, 0, 0, 0, 2, 0, 0, 1, 0, 0, 1, 0, 0);
    issue(3, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    issue(3, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    issue(3, 0, 0, 0, 7, 0, 0, 1, 0, 1, 1, 0, 0);
    idle(5);

    issue(2, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    issue(1, 3, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 3, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(5);

    issue(12, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    issue(9,  0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 1);
    issue(15, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 2);
    issue(5,  0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 3);
    issue(6,  0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 4);
    issue(9,  0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 5);
    idle(3);
    chk("illegal_cnt_total", 32'(illegal_cnt), 5);
    chk("illegal_cnt_saturated", 32'(s_illegal_cnt), 3);

    for (int r = 1; r <= 4; r++) issue(2, 0, 0, 0, r, 0, 0, 1, 0, 0, 1, 0, 0);
    idle(5);

    issue(2, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    issue(2, 0, 0, 0, 2, 0, 0, 1, 0, 0, 1, 0, 0);
    issue(3, 0, 0, 0, 3, 0, 0, 1, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("rstmid_ex_valid", 32'(ex_valid), 0);
    chk("rstmid_ex_alu", 32'(ex_alu_control), 0);
    chk("rstmid_ex_wen", 32'(ex_wen), 0);
    chk("rstmid_wb_write", 32'(wb_write), 0);
    chk("rstmid_wb_rd", 32'(wb_rd), 0);
    chk("rstmid_illegal", 32'(illegal), 0);
    chk("rstmid_illegal_cnt", 32'(illegal_cnt), 0);
    chk("rstmid_small_cnt", 32'(s_illegal_cnt), 0);
    exq.delete();
    wbq.delete();
    ilq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(6);

    chk("ex_queue_drained", exq.size(), 0);
    chk("wb_queue_drained", wbq.size(), 0);
    chk("illegal_queue_drained", ilq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
